tile_select_writer: RTL
=======================

# tile_select_writer

Parametrised tile-selection controller for the image-processing pipeline. It debounces-free synchronises the up/down/select push-buttons, steps a tile index across a GRID_COLS×GRID_ROWS grid with wrap-around, and computes the tile's pixel offsets and linear base address. On select it writes that address into the shared RAM as a little-endian multi-byte word, one byte per cycle, at a fixed mailbox address. It then hands RAM port A to the CPU (mode=1) until the CPU signals completion. It replaces the fixed 4×4, 32-bit, one-way selection path in the top level.

## Interface
- GRID_COLS, 4, tiles per row (≥1)
- GRID_ROWS, 4, tiles per column (≥1)
- TILE_W, 100, tile width in pixels
- TILE_H, 100, tile height in pixels
- IMG_W, 400, image row pitch in pixels
- ADDR_W, 19, RAM address width
- OFF_W, 9, width of h_offset/v_offset
- WORD_BYTES, 4, bytes in mailbox word; 8*WORD_BYTES ≥ ADDR_W
- BASE_ADDR, 19'h30E50, mailbox byte address (byte 0, LSB)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- up_btn  in  1  raw, active-low, asynchronous
- down_btn  in  1  raw, active-low, asynchronous
- select_btn  in  1  raw, active-low, asynchronous
- cpu_done  in  1  one-cycle pulse from the CPU: processing finished
- tile_idx  out  $clog2(GRID_COLS*GRID_ROWS) (min 1)  current tile index
- h_offset  out  OFF_W  col*TILE_W
- v_offset  out  OFF_W  row*TILE_H
- mode  out  1  0 = selection owns RAM port A, 1 = CPU owns it
- write_done  out  1  one-cycle pulse after the last mailbox byte
- ram_addr  out  ADDR_W  port-A address (selection side)
- ram_wdata  out  8  port-A write data
- ram_wren  out  1  port-A write enable

## Operation
- Each button goes through a 2-FF synchroniser (s1, s2) and a prev register. A press is ~s2 & prev, a falling edge, which gives one event per press.
- col = tile_idx % GRID_COLS, row = tile_idx / GRID_COLS.
- tile_addr = h_offset + IMG_W*v_offset. It is computed at full precision and then truncated to ADDR_W. The mailbox word is tile_addr zero-extended to 8*WORD_BYTES.
- States:
  - SELECT (mode=0):
    - An up press sets tile_idx+1, wrapping from N-1 to 0.
    - A down press sets tile_idx−1, wrapping from 0 to N−1.
    - Up and down in the same cycle: no change.
    - A select press latches the word, clears the byte counter and enters WRITE. A select press takes priority over up/down in the same cycle; tile_idx is unchanged.
  - WRITE (mode=0):
    - Each cycle: ram_wren=1, ram_addr=BASE_ADDR+cnt, ram_wdata=word[8*cnt +: 8], cnt+1.
    - After byte WORD_BYTES−1 the block enters PROCESS, pulses write_done and sets mode=1.
    - Buttons are ignored; a press pending during WRITE is discarded.
  - PROCESS (mode=1):
    - ram_wren=0. Buttons are ignored; prev registers keep tracking.
    - cpu_done returns the block to SELECT (mode=0) with tile_idx retained.
- cpu_done outside PROCESS is ignored.
- All outputs are registered.

## Timing
- Reset values:
  - state=SELECT, tile_idx=0, h_offset=0, v_offset=0, mode=0, write_done=0.
  - ram_addr=BASE_ADDR, ram_wdata=0, ram_wren=0, counters 0.
  - Synchroniser and prev registers are set to 1 (released).
- Button latency: if a button is sampled low at edge k, the press is detected after edge k+1, and tile_idx/offsets update at edge k+2.
- Select latency:
  - Select sampled low at edge k: ram_wren is high from edge k+2 through edge k+2+WORD_BYTES (exclusive), which is exactly WORD_BYTES cycles.
  - write_done=1 and mode=1 from edge k+2+WORD_BYTES.
  - write_done falls one cycle later; mode stays 1.
- cpu_done high at edge j (in PROCESS) gives mode=0 after edge j; the first press can act at edge j+1.
- Reset asserted mid-WRITE: at the next edge ram_wren=0 and reset values apply. A partially written mailbox is left as is; no done pulse is issued.
- Holding a button produces exactly one step; a new step requires release (≥1 cycle high at s2) followed by a new press.

## Test plan
- Reset, then up ×5 (each press 4 cycles low, 4 high) -> tile_idx=5, h_offset=100, v_offset=100.
- tile_idx=0, one down press -> tile_idx=15, h_offset=300, v_offset=300. Then one up press -> tile_idx=0.
- tile_idx=5, select -> four writes: 0x30E50=A4, 0x30E51=9C, 0x30E52=00, 0x30E53=00. The write_done pulse and mode=1 occur exactly at edge k+6 (WORD_BYTES=4).
- tile_idx=15, select -> bytes EC,D5,01,00 (0x1D5EC). Up/down presses in PROCESS leave tile_idx=15. A cpu_done pulse gives mode=0, and the next up gives tile_idx=0.
- up and down s2 falling in the same cycle -> tile_idx unchanged. Select together with up -> WRITE entered and tile_idx unchanged.
- rst pulse after the 2nd byte of WRITE -> ram_wren=0 at the next edge, no write_done, tile_idx=0, mode=0. Re-run with GRID_COLS=2, GRID_ROWS=3, WORD_BYTES=3: wrap at 5→0, exactly 3 write cycles.

Source files
------------

// File: rtl/tile_select_writer.sv
// -----------------------------------------------------------------------------
// tile_select_writer
//
// Tile-selection controller. Three raw active-low push-buttons are
// synchronised and edge-detected. Up/down step a tile index across a
// GRID_COLS x GRID_ROWS grid with wrap-around. The block also tracks the
// tile's pixel offsets. A select press writes the tile's linear base address
// into a RAM mailbox as a little-endian word, one byte per cycle. The block
// then hands RAM port A to the CPU until cpu_done arrives.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   up_btn     raw active-low "next tile" button
//   down_btn   raw active-low "previous tile" button
//   select_btn raw active-low "commit tile" button
//   cpu_done   one-cycle pulse: CPU finished with port A
//   tile_idx   current tile index
//   h_offset   col * TILE_W
//   v_offset   row * TILE_H
//   mode       0 = selection owns port A, 1 = CPU owns port A
//   write_done one-cycle pulse after the last mailbox byte
//   ram_addr   port-A byte address
//   ram_wdata  port-A write data
//   ram_wren   port-A write enable
// -----------------------------------------------------------------------------
module tile_select_writer #(
  parameter int GRID_COLS  = 4,
  parameter int GRID_ROWS  = 4,
  parameter int TILE_W     = 100,
  parameter int TILE_H     = 100,
  parameter int IMG_W      = 400,
  parameter int ADDR_W     = 19,
  parameter int OFF_W      = 9,
  parameter int WORD_BYTES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h30E50
) (
  input  logic clk,
  input  logic rst,
  input  logic up_btn,
  input  logic down_btn,
  input  logic select_btn,
  input  logic cpu_done,
  output logic [((GRID_COLS*GRID_ROWS > 1) ? $clog2(GRID_COLS*GRID_ROWS) : 1)-1:0] tile_idx,
  output logic [OFF_W-1:0]  h_offset,
  output logic [OFF_W-1:0]  v_offset,
  output logic              mode,
  output logic              write_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_wren
);

  localparam int N      = GRID_COLS * GRID_ROWS;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_SELECT  = 2'd0,
    ST_WRITE   = 2'd1,
    ST_PROCESS = 2'd2
  } state_t;

  state_t state_q;

  // Button order: 0 = up, 1 = down, 2 = select.
  logic [2:0] btn_raw;
  logic [2:0] press;
  assign btn_raw = {select_btn, down_btn, up_btn};

  // Sync chain and prev registers reset to 1 (released). The prev register
  // keeps tracking in every state, so a press is one pulse per falling edge
  // and anything seen outside SELECT is simply dropped.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q   <= 1'b1;
        s2_q   <= 1'b1;
        prev_q <= 1'b1;
      end else begin
        s1_q   <= btn_raw[gi];
        s2_q   <= s1_q;
        prev_q <= s2_q;
      end
    end
    assign press[gi] = ~s2_q & prev_q;
  end

  // Next tile index and its offsets. Select wins over up/down, and up and
  // down together cancel.
  logic [IDX_W-1:0] idx_d;
  logic [OFF_W-1:0] h_d, v_d;
  int col_d, row_d;

  always_comb begin
    idx_d = tile_idx;
    if (state_q == ST_SELECT && !press[2]) begin
      if (press[0] && !press[1]) begin
        idx_d = (tile_idx == IDX_MAX) ? '0 : tile_idx + IDX_W'(1);
      end else if (press[1] && !press[0]) begin
        idx_d = (tile_idx == '0) ? IDX_MAX : tile_idx - IDX_W'(1);
      end
    end
    col_d = int'(idx_d) % GRID_COLS;
    row_d = int'(idx_d) / GRID_COLS;
    h_d   = OFF_W'(col_d * TILE_W);
    v_d   = OFF_W'(row_d * TILE_H);
  end

  // Mailbox word. It is computed wide from the registered offsets, then
  // truncated to the RAM address width and zero-extended to the word width.
  logic [63:0]       addr_full;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  assign addr_full = 64'(h_offset) + 64'(IMG_W) * 64'(v_offset);
  assign word_d    = WORD_W'(addr_full[ADDR_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SELECT;
      tile_idx   <= '0;
      h_offset   <= '0;
      v_offset   <= '0;
      mode       <= 1'b0;
      write_done <= 1'b0;
      ram_addr   <= BASE_ADDR;
      ram_wdata  <= '0;
      ram_wren   <= 1'b0;
      word_q     <= '0;
      cnt_q      <= '0;
    end else begin
      write_done <= 1'b0;
      case (state_q)
        ST_SELECT: begin
          tile_idx <= idx_d;
          h_offset <= h_d;
          v_offset <= v_d;
          if (press[2]) begin
            // Byte 0 goes out on the same edge that latches the word. That
            // edge is the first of WORD_BYTES write cycles.
            word_q    <= word_d;
            ram_wren  <= 1'b1;
            ram_addr  <= BASE_ADDR;
            ram_wdata <= word_d[7:0];
            cnt_q     <= CNT_W'(1);
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (cnt_q == CNT_W'(WORD_BYTES)) begin
            ram_wren   <= 1'b0;
            write_done <= 1'b1;
            mode       <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_PROCESS;
          end else begin
            ram_wren  <= 1'b1;
            ram_addr  <= BASE_ADDR + ADDR_W'(cnt_q);
            ram_wdata <= word_q[8*int'(cnt_q) +: 8];
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        ST_PROCESS: begin
          ram_wren <= 1'b0;
          if (cpu_done) begin
            mode    <= 1'b0;
            state_q <= ST_SELECT;
          end
        end
        default: begin
          state_q <= ST_SELECT;
          mode    <= 1'b0;
        end
      endcase
    end
  end

endmodule
